// File: rtl/aes_pkg.sv
// Shared AES constants: byte/word widths, forward and inverse S-box tables,
// and the key-expansion round constants.
package aes_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  localparam logic [0:6][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Entry 0 is the leftmost byte of each table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/inv_s_box.sv
// 8-bit combinational inverse AES S-box lookup.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = INV_SBOX[a];

endmodule

// File: rtl/s_box.sv
// 8-bit combinational forward AES S-box lookup.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/sub_word_pipe.sv
// Handshaked SubWord / InvSubWord stage with optional RotWord and Rcon XOR,
// 1..3 register stages with valid/ready flow control.
module sub_word_pipe
  import aes_pkg::*;
#(
  parameter int NUM_BYTES   = WORD_BYTES,
  parameter int PIPE_STAGES = 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] in_word,
  input  logic                      in_inv,
  input  logic                      in_rot,
  input  logic [7:0]                in_rcon,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] out_word
);

  localparam int W = BYTE_W * NUM_BYTES;

  // Stage A holds the rotated word and controls, stage B the substituted
  // word; O is the output register. A exists for PIPE_STAGES >= 2, B for 3.
  logic         a_valid, a_inv;
  logic [W-1:0] a_word;
  logic [7:0]   a_rcon;
  logic         b_valid;
  logic [W-1:0] b_word;
  logic [7:0]   b_rcon;
  logic         o_valid;
  logic [W-1:0] o_word;

  logic o_load, b_load, a_load, accept;

  assign o_load   = !o_valid || out_ready;
  assign b_load   = !b_valid || o_load;
  assign a_load   = !a_valid || ((PIPE_STAGES == 3) ? b_load : o_load);
  assign in_ready = (PIPE_STAGES == 1) ? o_load : a_load;
  assign accept   = in_valid && in_ready;

  logic [W-1:0] rot_word;
  generate
    if (NUM_BYTES == 1) begin : g_no_rot
      assign rot_word = in_rot ? in_word : in_word;
    end else begin : g_rot
      assign rot_word = in_rot ? {in_word[W-BYTE_W-1:0], in_word[W-1 -: BYTE_W]} : in_word;
    end
  endgenerate

  generate
    if (PIPE_STAGES >= 2) begin : g_stage_a
      // NOTE: state registers use non-blocking assignment so every stage
      // samples its predecessor's value from before the clock edge.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  a_valid <= 1'b0;
        else if (a_load) a_valid <= in_valid;
      end

      // NOTE: data registers are deliberately unreset; their contents are
      // ignored whenever the matching valid bit is clear.
      always_ff @(posedge sys_clk) begin
        if (accept) begin
          a_word <= rot_word;
          a_inv  <= in_inv;
          a_rcon <= in_rcon;
        end
      end
    end else begin : g_no_stage_a
      assign a_valid = 1'b0;
      assign a_word  = '0;
      assign a_inv   = 1'b0;
      assign a_rcon  = '0;
    end
  endgenerate

  logic [W-1:0] sub_in, sub_word;
  logic         sub_inv;

  assign sub_in  = (PIPE_STAGES == 1) ? rot_word : a_word;
  assign sub_inv = (PIPE_STAGES == 1) ? in_inv   : a_inv;

  generate
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
      logic [7:0] fwd, inv;
      s_box     u_s_box     (.a(sub_in[i*BYTE_W +: BYTE_W]), .y(fwd));
      inv_s_box u_inv_s_box (.a(sub_in[i*BYTE_W +: BYTE_W]), .y(inv));
      assign sub_word[i*BYTE_W +: BYTE_W] = sub_inv ? inv : fwd;
    end
  endgenerate

  generate
    if (PIPE_STAGES == 3) begin : g_stage_b
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  b_valid <= 1'b0;
        else if (b_load) b_valid <= a_valid;
      end

      always_ff @(posedge sys_clk) begin
        if (b_load && a_valid) begin
          b_word <= sub_word;
          b_rcon <= a_rcon;
        end
      end
    end else begin : g_no_stage_b
      assign b_valid = 1'b0;
      assign b_word  = '0;
      assign b_rcon  = '0;
    end
  endgenerate

  logic [W-1:0] xor_in, result;
  logic [7:0]   xor_rcon;
  logic         feed_valid;

  assign xor_in     = (PIPE_STAGES == 3) ? b_word : sub_word;
  assign xor_rcon   = (PIPE_STAGES == 1) ? in_rcon  : (PIPE_STAGES == 2) ? a_rcon  : b_rcon;
  assign feed_valid = (PIPE_STAGES == 1) ? in_valid : (PIPE_STAGES == 2) ? a_valid : b_valid;

  // NOTE: the full default assignment first keeps this block latch-free
  // even though only the top byte is modified afterwards.
  always_comb begin
    result              = xor_in;
    result[W-1 -: BYTE_W] = xor_in[W-1 -: BYTE_W] ^ xor_rcon;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_valid <= 1'b0;
      o_word  <= '0;
    end else if (o_load) begin
      o_valid <= feed_valid;
      if (feed_valid) o_word <= result;
    end
  end

  assign out_valid = o_valid;
  assign out_word  = o_word;

endmodule

// File: tb/tb_sub_word_pipe.sv
// Directed self-checking bench for sub_word_pipe in three configurations:
// (4 bytes, 1 stage), (4 bytes, 3 stages) and (16 bytes, 2 stages).
module tb_sub_word_pipe;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        p1_in_valid, p1_in_ready, p1_in_inv, p1_in_rot, p1_out_valid, p1_out_ready;
  logic [31:0] p1_in_word, p1_out_word;
  logic [7:0]  p1_in_rcon;

  logic        p3_in_valid, p3_in_ready, p3_in_inv, p3_in_rot, p3_out_valid, p3_out_ready;
  logic [31:0] p3_in_word, p3_out_word;
  logic [7:0]  p3_in_rcon;

  logic         w_in_valid, w_in_ready, w_in_inv, w_in_rot, w_out_valid, w_out_ready;
  logic [127:0] w_in_word, w_out_word;
  logic [7:0]   w_in_rcon;

  sub_word_pipe #(.NUM_BYTES(4), .PIPE_STAGES(1)) u_p1 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_word(p1_in_word),
    .in_inv(p1_in_inv), .in_rot(p1_in_rot), .in_rcon(p1_in_rcon),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready), .out_word(p1_out_word)
  );

  sub_word_pipe #(.NUM_BYTES(4), .PIPE_STAGES(3)) u_p3 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(p3_in_valid), .in_ready(p3_in_ready), .in_word(p3_in_word),
    .in_inv(p3_in_inv), .in_rot(p3_in_rot), .in_rcon(p3_in_rcon),
    .out_valid(p3_out_valid), .out_ready(p3_out_ready), .out_word(p3_out_word)
  );

  sub_word_pipe #(.NUM_BYTES(16), .PIPE_STAGES(2)) u_w16 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_word(w_in_word),
    .in_inv(w_in_inv), .in_rot(w_in_rot), .in_rcon(w_in_rcon),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_word(w_out_word)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Hand-computed vectors for the 3-stage streaming tests.
  logic [31:0] v_word [10] = '{32'h00000000, 32'h01010101, 32'h00530000, 32'h0914DFF4, 32'h00112233,
                               32'h44556677, 32'h63ED6363, 32'h8899AABB, 32'hCCDDEEFF, 32'h7C7C7C7C};
  logic        v_inv  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        v_rot  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0]  v_rc   [10] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
  logic [31:0] v_exp  [10] = '{32'h63636363, 32'h7C7C7C7C, 32'h63ED6363, 32'hFB9EBF01, 32'h638293C3,
                               32'h1BFC33F5, 32'h00530000, 32'hEEACEAC4, 32'h6BC12816, 32'h01010101};

  task automatic drive_p3(input int i);
    p3_in_valid = 1'b1;
    p3_in_word  = v_word[i];
    p3_in_inv   = v_inv[i];
    p3_in_rot   = v_rot[i];
    p3_in_rcon  = v_rc[i];
  endtask

  // Single-stage: result must be visible right after the accepting edge.
  task automatic send1(input logic [31:0] w, input logic inv, input logic rot,
                       input logic [7:0] rc, input logic [31:0] exp, input string tag);
    @(negedge clk);
    p1_in_word = w; p1_in_inv = inv; p1_in_rot = rot; p1_in_rcon = rc; p1_in_valid = 1'b1;
    #1 check({tag, "_rdy"}, p1_in_ready, 1);
    @(posedge clk);
    #1 p1_in_valid = 1'b0;
    check({tag, "_v"}, p1_out_valid, 1);
    check({tag, "_w"}, p1_out_word, exp);
  endtask

  // Two-stage: idle after the accepting edge, valid one edge later.
  task automatic send16(input logic [127:0] w, input logic inv, input logic rot,
                        input logic [7:0] rc, input logic [127:0] exp, input string tag);
    @(negedge clk);
    w_in_word = w; w_in_inv = inv; w_in_rot = rot; w_in_rcon = rc; w_in_valid = 1'b1;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    check({tag, "_lat"}, w_out_valid, 0);
    @(posedge clk);
    #1 check({tag, "_v"}, w_out_valid, 1);
    check({tag, "_w"}, w_out_word, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_in, n_out;
    logic        stalled;
    logic [31:0] held;
    logic [7:0]  b;

    rst_n = 1'b0;
    p1_in_valid = 1'b0; p1_in_word = '0; p1_in_inv = 1'b0; p1_in_rot = 1'b0; p1_in_rcon = '0; p1_out_ready = 1'b1;
    p3_in_valid = 1'b0; p3_in_word = '0; p3_in_inv = 1'b0; p3_in_rot = 1'b0; p3_in_rcon = '0; p3_out_ready = 1'b1;
    w_in_valid  = 1'b0; w_in_word  = '0; w_in_inv  = 1'b0; w_in_rot  = 1'b0; w_in_rcon  = '0; w_out_ready  = 1'b1;

    #12;
    check("rst_p1_v", p1_out_valid, 0);
    check("rst_p1_w", p1_out_word, 0);
    check("rst_p3_v", p3_out_valid, 0);
    check("rst_w16_w", w_out_word, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_p1_rdy", p1_in_ready, 1);
    check("rst_p3_rdy", p3_in_ready, 1);
    check("rst_w16_rdy", w_in_ready, 1);

    send1(32'h00530000, 1'b0, 1'b0, 8'h00, 32'h63ED6363, "fwd");
    send1(32'h63ED6363, 1'b1, 1'b0, 8'h00, 32'h00530000, "inv");
    send1(32'h63ED6363, 1'b1, 1'b0, 8'h10, 32'h10530000, "inv_rcon");
    send1(32'h0914DFF4, 1'b0, 1'b1, 8'h01, 32'hFB9EBF01, "kexp");

    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i % 2 == 0) send1({4{b}}, 1'b0, 1'b0, 8'h00, {4{SBOX[b]}}, "stream_fwd");
      else            send1({4{SBOX[b]}}, 1'b1, 1'b0, 8'h00, {4{b}}, "stream_inv");
    end

    send16(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 1'b0, 8'h00,
           128'h638293C31BFC33F5C4EEACEA4BC12816, "w16_fwd");
    send16(128'h638293C31BFC33F5C4EEACEA4BC12816, 1'b1, 1'b0, 8'h00,
           128'h00112233445566778899AABBCCDDEEFF, "w16_inv");
    send16(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 1'b1, 8'h40,
           128'hC293C31BFC33F5C4EEACEA4BC1281663, "w16_rot");

    // Full throughput with out_ready high: word n appears in cycle n+3.
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n < 10) drive_p3(n);
      else        p3_in_valid = 1'b0;
      #1;
      if (n < 10) check("tp_rdy", p3_in_ready, 1);
      if (n >= 3 && n < 13) begin
        check("tp_v", p3_out_valid, 1);
        check("tp_w", p3_out_word, v_exp[n-3]);
      end else begin
        check("tp_idle", p3_out_valid, 0);
      end
    end

    // Random back-pressure: order preserved, held output stable while stalled.
    n_in = 0; n_out = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && n_out < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("bp_hold_v", p3_out_valid, 1);
        check("bp_hold_w", p3_out_word, held);
      end
      p3_out_ready = 1'($urandom_range(0, 1));
      if (n_in < 10) drive_p3(n_in);
      else           p3_in_valid = 1'b0;
      #1;
      if (p3_in_valid && p3_in_ready) n_in++;
      if (p3_out_valid && p3_out_ready) begin
        check("bp_w", p3_out_word, (n_out < 10) ? v_exp[n_out] : 32'hDEADBEEF);
        n_out++;
      end
      stalled = p3_out_valid && !p3_out_ready;
      held    = p3_out_word;
    end
    check("bp_count", n_out, 10);
    @(negedge clk) p3_in_valid = 1'b0; p3_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("bp_nodup", p3_out_valid, 0);

    // Asynchronous reset with three words in flight.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive_p3(n);
    end
    @(negedge clk) p3_in_valid = 1'b0;
    #1 check("rst_pre_v", p3_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_v", p3_out_valid, 0);
    check("rst_mid_w", p3_out_word, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_post_rdy", p3_in_ready, 1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) drive_p3(0);
      else        p3_in_valid = 1'b0;
      #1;
      if (n < 3) check("rst_post_idle", p3_out_valid, 0);
      else begin
        check("rst_post_v", p3_out_valid, 1);
        check("rst_post_w", p3_out_word, 32'h63636363);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_word_pipe.md
Name: sub_word_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle registered SubWord stage.
- Byte-wise substitutes a word of NUM_BYTES bytes through the forward or inverse AES S-box.
- Per transaction, optionally applies RotWord before substitution and XORs an Rcon byte into the MS byte after substitution.
- Sits between the AES-256 key-expansion controller and the round datapath. Computes SubWord(RotWord(w)) xor Rcon in one pass, plus plain or inverse SubWord for the decrypt path.

Parameters:
- NUM_BYTES, 4, byte lanes per word (1..16); word width W = 8*NUM_BYTES.
- PIPE_STAGES, 1, register stages from input acceptance to output (1..3).

Ports:
- sys_clk  input  1  single clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word presented.
- in_ready  output  1  block can accept the input word this cycle.
- in_word  input  W  word to substitute; byte 0 = in_word[7:0].
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box.
- in_rot  input  1  1 = rotate left one byte (RotWord) before substitution.
- in_rcon  input  8  XORed into the MS byte after substitution; 0x00 = no-op.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_word  output  W  substituted result.

Behaviour:
- Reset (sys_rst_n low, asynchronous): all stage valid bits cleared, out_valid = 0, out_word = 0, in_ready = 1 once reset deasserts. Data registers other than out_word may be left unreset.
- Accept: the input is taken on a rising edge when in_valid && in_ready.
- Output handshake: out_word/out_valid are held stable while out_valid && !out_ready. A transfer completes on out_valid && out_ready.
- Datapath, in order:
  - rot = in_rot ? {in_word[W-9:0], in_word[W-1:W-8]} : in_word. For NUM_BYTES = 1, rotation is identity.
  - sub[i] = in_inv ? InvSbox(rot[i]) : Sbox(rot[i]) for every byte lane i.
  - out = sub ^ {in_rcon, (W-8) zeros}.
  - Rcon applies in both modes.
- Pipelining:
  - PIPE_STAGES = 1: the whole datapath lies between the input and the single output register.
  - PIPE_STAGES = 2: mode, rotate and Rcon are registered with the rotated word; substitution and XOR sit before the output register.
  - PIPE_STAGES = 3: the substitution result gets an extra register before the XOR/output register.
- Latency: a word accepted at edge k has out_valid = 1 after edge k+PIPE_STAGES, provided no stall occurred.
- Stage advance: each stage has a valid bit. Stage s loads when stage s is empty or stage s itself advances.
- Ready: in_ready = !v1 || stage1_advances. The final stage advances on out_ready. This gives full throughput of 1 word/cycle with out_ready held high.
- Back-pressure: a stall propagates one stage per bubble; no word is dropped or duplicated. in_ready may depend combinationally on out_ready; it must not depend on in_valid.
- Simultaneous events:
  - Accepting into stage 1 while stage 1 advances in the same cycle is legal.
  - A word arriving as the output drains in the same cycle is legal.
- Reset mid-operation: in-flight words are discarded, with no partial output.
- Per-transaction controls: in_inv, in_rot and in_rcon are sampled with in_word and travel with it. Changing them between words must not affect words already in flight.

Decomposition:
- Shared package aes_pkg holds:
  - forward and inverse S-box tables as 256-entry localparam arrays;
  - Rcon constants (0x01,0x02,0x04,0x08,0x10,0x20,0x40);
  - byte/word width localparams.
- Forward lanes reuse the existing s_box module.
- One new sub-module, inv_s_box (8-bit combinational inverse S-box), is instantiated per lane alongside s_box, with a mux on in_inv.

Test Plan:
1. Forward, PIPE_STAGES = 1: in_word = 0x00530000, inv = 0, rot = 0, rcon = 0 -> out_word = 0x63ED6363 one cycle after acceptance.
2. Inverse: in_word = 0x63ED6363, inv = 1 -> out_word = 0x00530000. Then stream 256 words {b,b,b,b} alternating forward/inverse -> every result matches the aes_pkg tables.
3. Key-expansion: in_word = 0x0914DFF4, rot = 1, rcon = 0x01, inv = 0 -> out_word = 0xFB9EBF01 (FIPS-197 A.3, w[8]).
4. Back-pressure, PIPE_STAGES = 3: stream 10 words with random out_ready at 50% duty -> outputs are in order, none lost or duplicated, and out_word is stable during every stall. With out_ready = 1 throughout, one result per cycle after 3-cycle latency.
5. Reset mid-stream: assert sys_rst_n low asynchronously with 3 words in flight -> out_valid = 0 and out_word = 0 immediately. After release, in_ready = 1 and the next word 0x00000000 gives 0x63636363.
6. Width: NUM_BYTES = 16, PIPE_STAGES = 2, in_word = 0x00112233445566778899AABBCCDDEEFF, rot = 0 -> out_word = 0x638293C31BFC33F5C4EEACEA4BC12816.
